// File: rtl/ahb_isp_param_bank.sv
// AHB-Lite slave that holds the ISP run-time parameter words. It supports byte-lane writes, read-back
// and a frame-aligned commit. Define ISP_PARAM_SHADOW_EN for the staging/active double buffer.
module ahb_isp_param_bank #(
  parameter int          NUM_REGS = 8,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RST_VAL  = 32'h0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       HSEL,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic [31:0]                HWDATA,
  input  logic                       HREADY,
  output logic [31:0]                HRDATA,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  input  logic                       frame_start,
  output logic [(NUM_REGS-1)*32-1:0] param_out,
  output logic                       param_update,
  output logic                       commit_pending
);

  localparam int IDX_W = ADDR_W - 2;

  typedef struct packed {
    logic             valid;
    logic             write;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [2:0]       size;
  } dphase_t;

  dphase_t     dp_q;
  logic        accept;
  logic [3:0]  strb;
  logic [31:0] idx_ext;
  logic        in_range;
  logic        wr_en;
  logic        rd_en;
  logic        wr_param;
  logic [31:0] staging [1:NUM_REGS-1];

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, HADDR[31:ADDR_W], HTRANS[0]};

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_q <= '0;
    end else if (accept) begin
      dp_q.valid <= 1'b1;
      dp_q.write <= HWRITE;
      dp_q.idx   <= HADDR[ADDR_W-1:2];
      dp_q.off   <= HADDR[1:0];
      dp_q.size  <= HSIZE;
    end else begin
      dp_q.valid <= 1'b0;
    end
  end

  // NOTE: combinational outputs get a default first, so no path leaves them unassigned and no latch is inferred.
  always_comb begin
    strb = 4'b0000;
    case (dp_q.size)
      3'd0:    strb[dp_q.off] = 1'b1;
      3'd1:    strb = dp_q.off[1] ? 4'b1100 : 4'b0011;
      3'd2:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
  end

  assign idx_ext  = 32'(dp_q.idx);
  assign in_range = idx_ext < NUM_REGS;
  assign wr_en    = dp_q.valid & dp_q.write;
  assign rd_en    = dp_q.valid & ~dp_q.write;
  assign wr_param = wr_en & in_range & (idx_ext != 32'd0) & (|strb);

  // NOTE: the parameter bank is a register file, not RAM. Every word must come out of reset at RST_VAL,
  // so each word is reset explicitly.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int k = 1; k < NUM_REGS; k++) staging[k] <= RST_VAL;
    end else if (wr_param) begin
      for (int k = 1; k < NUM_REGS; k++) begin
        if (idx_ext == k) begin
          for (int b = 0; b < 4; b++) begin
            if (strb[b]) staging[k][8*b +: 8] <= HWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  // Reads see staging directly, so a read right behind a write returns the new data.
  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      if (idx_ext == 32'd0) HRDATA = {31'b0, commit_pending};
      for (int k = 1; k < NUM_REGS; k++) begin
        if (idx_ext == k) HRDATA = staging[k];
      end
    end
  end

`ifdef ISP_PARAM_SHADOW_EN
  logic [31:0] active [1:NUM_REGS-1];
  logic        pending_q;
  logic        update_q;
  logic        commit_set;
  logic        do_commit;

  assign commit_set = wr_en & (idx_ext == 32'd0) & strb[0] & HWDATA[0];
  assign do_commit  = frame_start & pending_q;

  // A COMMIT write that lands on a frame_start only arms the next frame. The copy takes pre-write staging.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pending_q <= 1'b0;
      update_q  <= 1'b0;
      for (int k = 1; k < NUM_REGS; k++) active[k] <= RST_VAL;
    end else begin
      update_q <= do_commit;
      if (commit_set)     pending_q <= 1'b1;
      else if (do_commit) pending_q <= 1'b0;
      if (do_commit) begin
        for (int k = 1; k < NUM_REGS; k++) active[k] <= staging[k];
      end
    end
  end

  assign commit_pending = pending_q;
  assign param_update   = update_q;

  always_comb begin
    param_out = '0;
    for (int k = 1; k < NUM_REGS; k++) param_out[32*(k-1) +: 32] = active[k];
  end
`else
  logic update_q;
  logic unused_frame_start;

  assign unused_frame_start = frame_start;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) update_q <= 1'b0;
    else          update_q <= wr_param;
  end

  assign commit_pending = 1'b0;
  assign param_update   = update_q;

  always_comb begin
    param_out = '0;
    for (int k = 1; k < NUM_REGS; k++) param_out[32*(k-1) +: 32] = staging[k];
  end
`endif

endmodule

// File: tb/tb_ahb_isp_param_bank.sv
// Scoreboard bench for ahb_isp_param_bank. The driver updates a word-array reference model and queues
// the expected reads and update pulses. A negedge monitor pops the queues and compares.
module tb_ahb_isp_param_bank;
  localparam int          NR = 8;
  localparam int          AW = 8;
  localparam logic [31:0] RV = 32'h5EED_0001;
  localparam int          W  = (NR-1)*32;
`ifdef ISP_PARAM_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic          HCLK, HRESETn, HSEL, HWRITE, HREADY, frame_start;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HREADYOUT, HRESP, param_update, commit_pending;
  logic [W-1:0]  param_out;

  ahb_isp_param_bank #(.NUM_REGS(NR), .ADDR_W(AW), .RST_VAL(RV)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .frame_start(frame_start), .param_out(param_out),
    .param_update(param_update), .commit_pending(commit_pending)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] val;
  } exp_t;

  exp_t upd_q[$];
  exp_t rd_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   checking = 1'b0;

  // Reference model: plain word arrays plus the transfer whose data phase is in flight.
  logic [31:0] m_stg [1:NR-1];
  logic [31:0] m_act [1:NR-1];
  bit          m_pending = 1'b0;
  bit          dp_valid = 1'b0;
  bit          dp_write = 1'b0;
  logic [31:0] dp_addr = '0;
  logic [2:0]  dp_size = '0;
  logic [31:0] dp_wdata = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_words(input bit from_active);
    logic [W-1:0] v;
    v = '0;
    for (int k = 1; k < NR; k++) v[32*(k-1) +: 32] = from_active ? m_act[k] : m_stg[k];
    return v;
  endfunction

  // A transfer of 2^size bytes occupies the naturally aligned group that contains the offset.
  function automatic logic [3:0] lanes(input logic [1:0] off, input logic [2:0] size);
    logic [3:0] l;
    int n, base;
    l = 4'b0000;
    if (size <= 3'd2) begin
      n = 1 << size;
      base = int'(off) - (int'(off) % n);
      for (int b = 0; b < 4; b++) l[b] = (b >= base) && (b < base + n);
    end
    return l;
  endfunction

  function automatic logic [31:0] read_val(input logic [31:0] addr);
    int idx;
    idx = int'(addr[AW-1:2]);
    if (idx == 0) return {31'b0, m_pending};
    if (idx < NR) return m_stg[idx];
    return 32'h0;
  endfunction

  task automatic model_edge(input bit acc, input bit wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata,
                            input bit fs, input bit rst_n);
    bit commit, set;
    int idx;
    logic [3:0] l;
    if (!rst_n) begin
      for (int k = 1; k < NR; k++) begin
        m_stg[k] = RV;
        m_act[k] = RV;
      end
      m_pending = 1'b0;
      dp_valid = 1'b0;
      return;
    end
    commit = SHADOW && fs && m_pending;
    set = 1'b0;
    if (commit) begin
      for (int k = 1; k < NR; k++) m_act[k] = m_stg[k];
      upd_q.push_back('{cyc, pack_words(1'b1)});
    end
    if (dp_valid && dp_write) begin
      idx = int'(dp_addr[AW-1:2]);
      l = lanes(dp_addr[1:0], dp_size);
      if (idx >= 1 && idx < NR && l != 4'b0000) begin
        for (int b = 0; b < 4; b++) if (l[b]) m_stg[idx][8*b +: 8] = dp_wdata[8*b +: 8];
        if (!SHADOW) upd_q.push_back('{cyc, pack_words(1'b0)});
      end else if (idx == 0 && l[0] && dp_wdata[0] && SHADOW) begin
        set = 1'b1;
      end
    end
    if (set)         m_pending = 1'b1;
    else if (commit) m_pending = 1'b0;
    dp_valid = acc;
    dp_write = wr;
    dp_addr  = addr;
    dp_size  = size;
    dp_wdata = wdata;
    if (acc && !wr) rd_q.push_back('{cyc, W'(read_val(addr))});
  endtask

  // Drive one cycle: a new address phase plus the data of the previous transfer.
  task automatic xfer(input bit sel, input logic [1:0] trans, input bit rdy, input bit wr,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                      input bit fs, input bit rst_n);
    HSEL = sel;
    HTRANS = trans;
    HREADY = rdy;
    HWRITE = wr;
    HADDR = addr;
    HSIZE = size;
    HWDATA = dp_wdata;
    frame_start = fs;
    HRESETn = rst_n;
    @(posedge HCLK);
    #1;
    model_edge(sel & rdy & trans[1], wr, addr, size, wdata, fs, rst_n);
  endtask

  task automatic idle(input bit fs = 1'b0, input bit rst_n = 1'b1);
    xfer(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 3'd0, 32'h0, fs, rst_n);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                    input bit fs = 1'b0);
    xfer(1'b1, 2'b10, 1'b1, 1'b1, addr, size, data, fs, 1'b1);
  endtask

  task automatic rd(input logic [31:0] addr);
    xfer(1'b1, 2'b10, 1'b1, 1'b0, addr, 3'd2, 32'h0, 1'b0, 1'b1);
  endtask

  always @(negedge HCLK) begin
    bit exp_pulse;
    if (checking) begin
      exp_pulse = (upd_q.size() > 0) && (upd_q[0].cyc == cyc);
      check("param_update", W'(param_update), W'(exp_pulse));
      if (exp_pulse) begin
        check("param_out_at_update", param_out, upd_q[0].val);
        void'(upd_q.pop_front());
      end
      check("param_out", param_out, pack_words(SHADOW));
      check("commit_pending", W'(commit_pending), W'(m_pending));
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        check("hrdata_read", W'(HRDATA), rd_q[0].val);
        void'(rd_q.pop_front());
      end else begin
        check("hrdata_idle", W'(HRDATA), W'(32'h0));
      end
      check("hreadyout", W'(HREADYOUT), W'(1'b1));
      check("hresp", W'(HRESP), W'(1'b0));
    end
  end

  initial begin
    logic [31:0] addr, data;
    logic [2:0]  size;
    int          idx;
    HRESETn = 1'b0;
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HREADY = 1'b1;
    HWRITE = 1'b0;
    HADDR = '0;
    HSIZE = '0;
    HWDATA = '0;
    frame_start = 1'b0;
    for (int k = 1; k < NR; k++) begin
      m_stg[k] = RV;
      m_act[k] = RV;
    end

    idle(1'b0, 1'b0);
    checking = 1'b1;
    idle(1'b0, 1'b0);
    idle();

    // Reset lands during the data phase of a write to index 2.
    wr(32'h8, 3'd2, 32'h1111_2222);
    wr(32'h8, 3'd2, 32'h3333_4444);
    idle(1'b0, 1'b0);
    idle();
    rd(32'h8);
    idle();

    // Back-to-back word writes, then read-back, then an immediate read-after-write.
    wr(32'h4, 3'd2, 32'h2349_8701);
    wr(32'h8, 3'd2, 32'hAB9C_8F00);
    rd(32'h4);
    rd(32'h8);
    wr(32'h10, 3'd2, 32'hCAFE_0010);
    rd(32'h10);
    idle();

    // Byte and halfword lanes.
    wr(32'h6, 3'd0, {4{8'h5A}});
    wr(32'hA, 3'd1, {2{16'hBEEF}});
    rd(32'h4);
    rd(32'h8);
    idle();

    // Commit on a later frame_start.
    wr(32'h0, 3'd2, 32'h1);
    idle();
    rd(32'h0);
    idle();
    idle(1'b1);
    idle();
    rd(32'h0);
    idle();

    // The COMMIT write completes in the same cycle as frame_start.
    wr(32'h0, 3'd2, 32'h1);
    idle(1'b1);
    idle();
    idle();
    idle(1'b1);
    idle();

    // Writing 0 to CTRL, and a CTRL write that leaves lane 0 unstrobed, do nothing.
    wr(32'h0, 3'd2, 32'h0);
    wr(32'h1, 3'd0, 32'hFFFF_FFFF);
    rd(32'h0);
    idle(1'b1);
    idle();

    // Out-of-range write and read.
    wr(32'h20, 3'd2, 32'hDEAD_BEEF);
    rd(32'h20);
    rd(32'h4);
    idle();

    // Randomized traffic with frame starts and occasional resets.
    for (int i = 0; i < 600; i++) begin
      idx  = int'($urandom_range(0, 9));
      size = 3'($urandom_range(0, 2));
      addr = ($urandom & 32'hFFFF_FF00) | 32'(idx << 2);
      if (size == 3'd0) addr[1:0] = 2'($urandom_range(0, 3));
      if (size == 3'd1) addr[1:0] = {1'($urandom_range(0, 1)), 1'b0};
      data = $urandom;
      xfer(($urandom % 8) != 0, 2'($urandom_range(0, 3)), ($urandom % 8) != 0, 1'($urandom_range(0, 1)),
           addr, size, data, ($urandom % 6) == 0, ($urandom % 150) != 0);
    end

    idle();
    idle();
    idle();
    check("update_queue_drained", W'(upd_q.size()), W'(0));
    check("read_queue_drained", W'(rd_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_isp_param_bank.md
Name: ahb_isp_param_bank

Overview:
- Parametrised AHB-Lite slave holding the ISP pipeline's run-time parameter words (gain, thresholds, colour coefficients).
- Replaces the fixed three-word parameter decode in the ISP subsystem with a NUM_REGS-deep bank.
- Adds byte-lane writes, read-back and a commit mechanism, so parameters change only on a frame boundary.
- Sits between the AHB interconnect and the ISP datapath, all on HCLK.

Parameters:
- NUM_REGS, 8, total word registers. Index 0 is CTRL; indices 1..NUM_REGS-1 are parameters. Legal range 2..64.
- ADDR_W, 8, number of low HADDR bits decoded. Must satisfy 2^(ADDR_W-2) >= NUM_REGS.
- RST_VAL, 32'h0, reset value of every parameter word, both staging and active.

Ports:
- HCLK  in  1  system clock; the only clock.
- HRESETn  in  1  synchronous active-low reset, sampled on the HCLK rising edge.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; only [ADDR_W-1:0] decoded.
- HTRANS  in  2  transfer type; NONSEQ and SEQ are valid.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  always 1; zero wait states.
- HRESP  out  1  always 0 (OKAY).
- frame_start  in  1  one-cycle pulse at the start of each ISP frame.
- param_out  out  (NUM_REGS-1)*32  active parameters; word k-1 sits at bits [32k-1:32k-32].
- param_update  out  1  one-cycle pulse when the active set changes.
- commit_pending  out  1  mirror of CTRL bit 0.

Behaviour:
- Address phase is accepted when HSEL & HREADY & HTRANS[1].
  - On acceptance, register the following: the index from HADDR[ADDR_W-1:2], HADDR[1:0], HSIZE, HWRITE, and a valid flag.
  - When not accepted, the valid flag clears.
- Data-phase write, when the valid flag is set and the registered HWRITE is 1:
  - Byte strobes come from size and offset.
    - Byte: lane = HADDR[1:0].
    - Halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
    - Word: all four lanes.
  - Only strobed bytes of the staging register update, at the end of the data phase.
  - Index >= NUM_REGS: write is dropped, no error.
- Data-phase read:
  - HRDATA is combinational from the registered index.
  - Parameter reads return the staging value.
  - CTRL reads return {31'b0, commit_pending}.
  - Out-of-range index, or no read data phase, returns 0.
- Read-after-write to the same register in back-to-back transfers returns the new data.
- CTRL bit 0 (COMMIT):
  - Writing 1 with lane 0 strobed sets commit_pending.
  - Writing 0 has no effect.
  - Bits 31:1 are read-only 0.
- Commit:
  - On a frame_start cycle with commit_pending = 1, all staging words copy to active.
  - commit_pending clears and param_update pulses high in the next cycle.
  - param_out reflects the new values from that same next cycle.
- Simultaneous events:
  - COMMIT write completing in the same cycle as frame_start: pending is set, and the copy waits for the next frame_start.
  - Parameter write completing in the same cycle as a commit: the active copy takes the pre-write value. The new value stays in staging.
  - frame_start with no pending commit: no change and no pulse.
- Reset, including mid-transfer or mid-commit:
  - Staging and active words = RST_VAL.
  - commit_pending = 0, param_update = 0, valid flag = 0.
  - HRDATA = 0, HREADYOUT = 1, HRESP = 0.
- Latency:
  - Write to staging: 0 cycles after the data phase.
  - Staging to active: 1 cycle after the qualifying frame_start.

Optional Feature:
- Macro: ISP_PARAM_SHADOW_EN.
- Defined: double-buffered behaviour exactly as described above.
- Undefined:
  - There is no active copy; param_out is driven directly from staging.
  - param_update pulses in the cycle after any completed in-range parameter write.
  - COMMIT writes are ignored, and commit_pending is tied 0.
  - frame_start is unused.

Test Plan:
1. Reset mid-transfer:
   - Stimulus: assert HRESETn=0 during a write data phase to index 2.
   - Required response: param_out all RST_VAL, HRDATA=0, commit_pending=0.
2. Word write and read-back:
   - Stimulus: write 32'h23498701 to 0x4, then 32'hAB9C8F00 to 0x8, back-to-back; read both.
   - Required response: reads return the same values.
   - Required response: param_out unchanged before commit (SHADOW_EN).
3. Byte and halfword lanes:
   - Stimulus: byte write 8'h5A to 0x6, then halfword 16'hBEEF to 0xA.
   - Required response: word 1 = 32'h235A8701, word 2 = 32'hBEEF8F00.
4. Commit:
   - Stimulus: write 1 to 0x0, then pulse frame_start.
   - Required response: param_update pulses once in the cycle after frame_start.
   - Required response: param_out word0 = 32'h235A8701, commit_pending = 0.
5. Simultaneous COMMIT write and frame_start:
   - Stimulus: COMMIT write completes in the same cycle as frame_start.
   - Required response: no update at that frame_start.
   - Required response: update occurs at the next frame_start.
6. Out-of-range write:
   - Stimulus: write to 0x20 with NUM_REGS=8.
   - Required response: no state change, read returns 0, HRESP=0.
   - Build variant: with ISP_PARAM_SHADOW_EN undefined, a write to 0x4 shows on param_out the next cycle with a param_update pulse.
